serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width in bits, legal range >= 2.
REQ-002 SHALL have parameter BITS_PER_CYCLE, default 1: bits subtracted per step, legal range 1..WIDTH, must divide WIDTH.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request to capture operands and begin.
REQ-006 SHALL have port a, input, WIDTH bits: minuend.
REQ-007 SHALL have port b, input, WIDTH bits: subtrahend.
REQ-008 SHALL have port bin, input, 1 bit: borrow-in.
REQ-009 SHALL have port busy, output, 1 bit: high while a subtraction is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port diff, output, WIDTH bits: result.
REQ-012 SHALL have port bout, output, 1 bit: borrow-out of the MSB.
REQ-013 SHALL have port ovf, output, 1 bit: signed (two's-complement) overflow.

Function
REQ-014 SHALL compute a - b - bin, LSB-first, BITS_PER_CYCLE bits per step, with the borrow chained between steps in a register; N = WIDTH/BITS_PER_CYCLE steps.
REQ-015 SHALL implement the FSM IDLE -> RUN -> DONE, with DONE -> RUN on start, otherwise DONE -> IDLE.
REQ-016 SHALL, when start is sampled high in IDLE or DONE, capture a, b and bin at that edge (the capture edge) and enter RUN.
REQ-017 SHALL perform one step per rising edge in RUN, with the N-th step at capture edge + N, then enter DONE.
REQ-018 SHALL hold busy = 1 exactly while in RUN, i.e. for N cycles.
REQ-019 SHALL assert done = 1 only in DONE, for exactly one cycle, beginning N edges after the capture edge.
REQ-020 SHALL update diff, bout and ovf only on entry to DONE, and hold them until the next completion.
REQ-021 SHALL ignore start while in RUN; captured operands SHALL be unaffected.
REQ-022 SHALL ignore changes to a, b and bin after the capture edge.
REQ-023 SHALL compute ovf = (a[MSB] ^ b[MSB]) & (a[MSB] ^ raw_diff[MSB]) from the captured operands and the unsaturated difference.
REQ-024 SHALL set bout = 1 exactly when a < b + bin, using unsigned comparison.

Reset
REQ-025 SHALL, while rst is high at a rising edge, enter IDLE and set busy=0, done=0, diff=0, bout=0, ovf=0, and clear the internal borrow, step counter and operand registers.
REQ-026 SHALL abort an in-progress operation when rst is asserted in RUN, with no done pulse and no partial result visible.
REQ-027 SHALL give rst priority over start at the same edge.

Configuration
REQ-028 SHALL, when macro SERIAL_SUB_SAT_EN is defined, force diff to 0 when bout = 1 (unsigned floor), with bout and ovf unchanged.
REQ-029 SHALL, when SERIAL_SUB_SAT_EN is undefined, produce diff = (a - b - bin) mod 2^WIDTH.

Verification
REQ-030 SHALL cover: WIDTH=8, BPC=1, a=0x35, b=0x12, bin=0 -> diff=0x23, bout=0, ovf=0; done 8 edges after capture; busy high 8 cycles.
REQ-031 SHALL cover: a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, ovf=0 (with SERIAL_SUB_SAT_EN: diff=0x00, bout=1).
REQ-032 SHALL cover: a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1; then a=0x05, b=0x05, bin=1 -> diff=0xFF, bout=1, ovf=0.
REQ-033 SHALL cover: start re-pulsed at RUN cycle 2 with a=0xFF, b=0xFF -> ignored, result of the first operation; start in the DONE cycle -> back-to-back RUN, no IDLE cycle.
REQ-034 SHALL cover: rst asserted at RUN cycle 3 -> next cycle busy=0, done=0, diff=0, bout=0, ovf=0; no done pulse follows.
REQ-035 SHALL cover: WIDTH=8, BPC=4, a=0x10, b=0x01, bin=0 -> diff=0x0F, bout=0; done 2 edges after capture.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle a - b - bin, computed LSB-first in
// BITS_PER_CYCLE-bit chunks with the borrow carried between steps in a
// register. Result, borrow-out and signed overflow are published together
// when the last chunk completes.
// Optional feature: define SERIAL_SUB_SAT_EN to floor the difference at 0
// whenever the subtraction borrows out of the MSB (bout and ovf unchanged).
module serial_subtractor #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t state;
  state_t state_next;

  // Captured operands stay unshifted; the active chunk is selected by cnt.
  logic [WIDTH-1:0]          a_q;
  logic [WIDTH-1:0]          b_q;
  logic [WIDTH-1:0]          acc;
  logic                      borrow;
  logic [CNT_W-1:0]          cnt;

  logic [IDX_W-1:0]          base;
  logic [BITS_PER_CYCLE-1:0] a_chunk;
  logic [BITS_PER_CYCLE-1:0] b_chunk;
  logic [BITS_PER_CYCLE:0]   step;
  logic                      step_borrow;
  logic [WIDTH-1:0]          chunk_ext;
  logic [WIDTH-1:0]          acc_next;
  logic                      last_step;
  logic                      capture;

  // Unsigned floor: a borrow out of the MSB means the true result is negative.
  function automatic logic [WIDTH-1:0] sat_floor(input logic [WIDTH-1:0] raw,
                                                 input logic             brw);
`ifdef SERIAL_SUB_SAT_EN
    return brw ? '0 : raw;
`else
    return (brw & 1'b0) ? '0 : raw;
`endif
  endfunction

  // Two's-complement overflow of a - b: operand signs differ and the result
  // sign does not follow the minuend.
  function automatic logic signed_ovf(input logic a_msb,
                                      input logic b_msb,
                                      input logic r_msb);
    return (a_msb ^ b_msb) & (a_msb ^ r_msb);
  endfunction

  // One chunk of the subtraction plus the shift-in of its result bits.
  always_comb begin
    base        = IDX_W'(cnt) * IDX_W'(BITS_PER_CYCLE);
    a_chunk     = a_q[base +: BITS_PER_CYCLE];
    b_chunk     = b_q[base +: BITS_PER_CYCLE];
    step        = {1'b0, a_chunk} - {1'b0, b_chunk}
                  - {{BITS_PER_CYCLE{1'b0}}, borrow};
    step_borrow = step[BITS_PER_CYCLE];
    chunk_ext   = WIDTH'(step[BITS_PER_CYCLE-1:0]);
    acc_next    = (acc >> BITS_PER_CYCLE) | (chunk_ext << (WIDTH - BITS_PER_CYCLE));
    last_step   = (cnt == LAST);
    capture     = start && ((state == IDLE) || (state == DONE));
  end

  // Next-state logic: start is honoured only outside RUN.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; reset wins over any start at the same edge.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Operand capture, per-step accumulation and result publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (capture) begin
      a_q    <= a;
      b_q    <= b;
      borrow <= bin;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      acc    <= acc_next;
      borrow <= step_borrow;
      if (last_step) begin
        cnt  <= '0;
        diff <= sat_floor(acc_next, step_borrow);
        bout <= step_borrow;
        ovf  <= signed_ovf(a_q[WIDTH-1], b_q[WIDTH-1], acc_next[WIDTH-1]);
      end else begin
        cnt  <= cnt + 1'b1;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: two instances (1 and 4 bits per step) share
// stimulus; a countdown/arithmetic reference model predicts every output on
// every cycle, and directed operations pin literal results and latencies.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;

  logic       busy8, done8, bout8, ovf8;
  logic [7:0] diff8;
  logic       busy4, done4, bout4, ovf4;
  logic [7:0] diff4;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference model state, index 0 = 1 bit/step, index 1 = 4 bits/step.
  int         nstep [2] = '{8, 2};
  int         m_rem [2];
  logic       m_done[2];
  logic [7:0] m_diff[2];
  logic       m_bout[2];
  logic       m_ovf [2];
  logic [7:0] p_diff[2];
  logic       p_bout[2];
  logic       p_ovf [2];

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut8 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8));

  serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .ovf(ovf4));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Plain integer arithmetic: unsigned result/borrow, signed range overflow.
  task automatic model_op(input logic [7:0] x, input logic [7:0] y, input logic c,
                          output logic [7:0] d, output logic bo, output logic ov);
    int r, sx, sy, s;
    r  = int'(x) - int'(y) - int'(c);
    sx = $signed(x);
    sy = $signed(y);
    s  = sx - sy - int'(c);
    bo = (r < 0);
    d  = r[7:0];
    ov = (s > 127) || (s < -128);
`ifdef SERIAL_SUB_SAT_EN
    if (bo) d = 8'h00;
`endif
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_rem[i] = 0; m_done[i] = 1'b0;
        m_diff[i] = 8'h00; m_bout[i] = 1'b0; m_ovf[i] = 1'b0;
      end else if (m_rem[i] > 0) begin
        m_rem[i]--;
        if (m_rem[i] == 0) begin
          m_done[i] = 1'b1;
          m_diff[i] = p_diff[i]; m_bout[i] = p_bout[i]; m_ovf[i] = p_ovf[i];
        end
      end else begin
        m_done[i] = 1'b0;
        if (start) begin
          m_rem[i] = nstep[i];
          model_op(a, b, bin, p_diff[i], p_bout[i], p_ovf[i]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy8", busy8, m_rem[0] > 0);
      chk("done8", done8, m_done[0]);
      chk("diff8", diff8, m_diff[0]);
      chk("bout8", bout8, m_bout[0]);
      chk("ovf8",  ovf8,  m_ovf[0]);
      chk("busy4", busy4, m_rem[1] > 0);
      chk("done4", done4, m_done[1]);
      chk("diff4", diff4, m_diff[1]);
      chk("bout4", bout4, m_bout[1]);
      chk("ovf4",  ovf4,  m_ovf[1]);
    end
  end

  // Called at #1 after a rising edge; returns #1 after the edge where done8 rises.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                        input bit repulse, output int e8, output int e4, output int nbusy);
    start = 1'b1; a = ta; b = tb_v; bin = tc;
    @(posedge clk); #1;
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
    chk("busy_after_capture", busy8, 1'b1);
    e8 = 0; e4 = 0; nbusy = busy8 ? 1 : 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done4 && e4 == 0) e4 = k;
      if (done8) begin e8 = k; break; end
      if (busy8) nbusy++;
      if (repulse && k == 1) begin start = 1'b1; a = 8'hFF; b = 8'hFF; end
      if (repulse && k == 2) start = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic expect_res(input string nm, input logic [7:0] d, input logic bo, input logic ov);
    chk({nm, "_diff"}, diff8, d);
    chk({nm, "_bout"}, bout8, bo);
    chk({nm, "_ovf"},  ovf8,  ov);
  endtask

  logic [7:0] md;
  logic       mb, mo;
  logic [7:0] neg1;
  int e8, e4, nb, seen;

  initial begin
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; bin = 1'b0;
`ifdef SERIAL_SUB_SAT_EN
    neg1 = 8'h00;
`else
    neg1 = 8'hFF;
`endif
    @(posedge clk); #1;
    chk_en = 1'b1;
    idle(2);
    chk("rst_busy", busy8, 1'b0);
    chk("rst_done", done8, 1'b0);
    chk("rst_diff", diff8, 8'h00);
    rst = 1'b0;
    idle(2);

    // Model pins against hand-computed values.
    model_op(8'h35, 8'h12, 1'b0, md, mb, mo);
    chk("model_35_12", {md, mb, mo}, {8'h23, 1'b0, 1'b0});
    model_op(8'h80, 8'h01, 1'b0, md, mb, mo);
    chk("model_80_01", {md, mb, mo}, {8'h7F, 1'b0, 1'b1});
    model_op(8'h05, 8'h05, 1'b1, md, mb, mo);
    chk("model_05_05_1", {md, mb, mo}, {neg1, 1'b1, 1'b0});

    run_op(8'h35, 8'h12, 1'b0, 1'b0, e8, e4, nb);
    chk("lat8", e8, 8);
    chk("lat4", e4, 2);
    chk("busy_cycles8", nb, 8);
    expect_res("op35", 8'h23, 1'b0, 1'b0);
    chk("op35_diff4", diff4, 8'h23);
    idle(2);

    run_op(8'h00, 8'h01, 1'b0, 1'b0, e8, e4, nb);
    expect_res("op00", neg1, 1'b1, 1'b0);

    idle(1);
    run_op(8'h80, 8'h01, 1'b0, 1'b0, e8, e4, nb);
    expect_res("op80", 8'h7F, 1'b0, 1'b1);
    run_op(8'h05, 8'h05, 1'b1, 1'b0, e8, e4, nb);
    chk("b2b_lat8", e8, 8);
    expect_res("op05", neg1, 1'b1, 1'b0);
    idle(2);

    run_op(8'h35, 8'h12, 1'b0, 1'b1, e8, e4, nb);
    chk("repulse_lat8", e8, 8);
    expect_res("repulse", 8'h23, 1'b0, 1'b0);
    idle(2);

    run_op(8'h80, 8'h01, 1'b0, 1'b0, e8, e4, nb);
    idle(2);
    start = 1'b1; a = 8'h35; b = 8'h12; bin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    idle(2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", busy8, 1'b0);
    chk("abort_done", done8, 1'b0);
    expect_res("abort", 8'h00, 1'b0, 1'b0);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done8) seen++;
    end
    chk("abort_no_done", seen, 0);

    run_op(8'h10, 8'h01, 1'b0, 1'b0, e8, e4, nb);
    chk("bpc4_lat", e4, 2);
    chk("bpc4_diff", diff4, 8'h0F);
    chk("bpc4_bout", bout4, 1'b0);
    idle(2);

    for (int k = 0; k < 1500; k++) begin
      logic [7:0] pick [5];
      pick = '{8'h00, 8'hFF, 8'h80, 8'h7F, 8'($urandom)};
      @(posedge clk); #1;
      rst   = ($urandom_range(0, 79) == 0);
      start = ($urandom_range(0, 2) == 0);
      a     = pick[$urandom_range(0, 4)];
      b     = pick[$urandom_range(0, 4)];
      bin   = 1'($urandom);
    end
    rst = 1'b0; start = 1'b0;
    idle(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
